hssl_link_mon: RTL and testbench
================================

HSSL_LINK_MON -- requirements
Module: hssl_link_mon

Interface
REQ-001 The block SHALL have parameter HS_COUNT, default 8: consecutive handshake words required to declare link up.
REQ-002 The block SHALL have parameter ERR_LIMIT, default 4: consecutive errored words that drop an up link.
REQ-003 The block SHALL have parameter WDOG_CYCLES, default 1024: idle-free cycles tolerated while up (watchdog build only).
REQ-004 The block SHALL have port clk, input, 1 bit: single clock, GTH rx user clock.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port rx_data, input, 32 bits: received word.
REQ-007 The block SHALL have port rx_charisk, input, 4 bits: K-character flags, bit 3 maps to rx_data[31:24].
REQ-008 The block SHALL have port rx_err, input, 1 bit: disparity or not-in-table error for this word.
REQ-009 The block SHALL have port rx_aligned, input, 1 bit: byte alignment achieved.
REQ-010 The block SHALL have port clr_cnt, input, 1 bit: synchronous counter clear, level-sensitive, VIO driven.
REQ-011 The block SHALL have port link_up, output, 1 bit: link state is UP.
REQ-012 The block SHALL have port state, output, 3 bits: FSM state code.
REQ-013 The block SHALL have port hs_cnt, output, 16 bits: handshake words seen, saturating.
REQ-014 The block SHALL have port err_cnt, output, 16 bits: errored words seen, saturating.
REQ-015 The block SHALL have port frm_cnt, output, 32 bits: frame-start words seen while UP, wrapping.

Function
REQ-016 A handshake word SHALL be defined as rx_charisk==4'b1000 and rx_data[31:24]==8'hBC (K28.5).
REQ-017 A frame-start word SHALL be defined as rx_charisk==4'b1000 and rx_data[31:24]==8'hFB (K27.7).
REQ-018 An errored word SHALL be defined as rx_err==1, or rx_charisk not in {4'b0000, 4'b1000}.
REQ-019 State codes SHALL be: DOWN=3'd0, ALIGNED=3'd1, HSHAKE=3'd2, UP=3'd3, with all other codes unused.
REQ-020 From any state, rx_aligned==0 SHALL force DOWN on the next edge; this has the highest priority.
REQ-021 DOWN SHALL transition to ALIGNED when rx_aligned==1.
REQ-022 ALIGNED SHALL transition to HSHAKE on a handshake word, loading run count 1.
REQ-023 In HSHAKE, each handshake word SHALL increment the run count.
REQ-024 In HSHAKE, any non-handshake word SHALL return the FSM to ALIGNED and clear the run count.
REQ-025 HSHAKE SHALL transition to UP on the edge where the run count reaches HS_COUNT, i.e. UP is visible HS_COUNT cycles after the first handshake word.
REQ-026 In UP, ERR_LIMIT consecutive errored words SHALL return the FSM to ALIGNED.
REQ-027 In UP, any non-errored word SHALL reset the consecutive-error count.
REQ-028 All outputs SHALL be registered with one-cycle latency from the input word; link_up SHALL equal (state==UP).
REQ-029 hs_cnt and err_cnt SHALL count in all states except DOWN and saturate at 16'hFFFF.
REQ-030 frm_cnt SHALL count only in UP and wrap from 32'hFFFFFFFF to 0.
REQ-031 clr_cnt SHALL zero all three counters on the next edge and SHALL win over a simultaneous count event; FSM state SHALL be unaffected.

Reset
REQ-032 Assertion of rst_n==0 SHALL immediately force state=DOWN, link_up=0, all counters and run counts to 0.
REQ-033 Deassertion of rst_n SHALL be synchronised internally (two-flop) before releasing the FSM and counters.
REQ-034 Reset mid-frame or mid-handshake SHALL discard all partial progress.

Configuration
REQ-035 With HSSL_LINK_MON_WDOG_EN defined, a WDOG_CYCLES-cycle counter SHALL run in UP, reset on every handshake word, and force ALIGNED on expiry.
REQ-036 Without HSSL_LINK_MON_WDOG_EN, no watchdog logic SHALL exist, and UP SHALL be left only per REQ-020 and REQ-026.

Verification
REQ-037 Reset, then rx_aligned=1 and 8 handshake words -> state 0, 1, 2 ... 3; link_up=1 one cycle after the 8th word; hs_cnt=8.
REQ-038 5 handshake words, 1 data word, then 8 handshake words -> return to ALIGNED after the data word; UP only after the later 8-word run.
REQ-039 In UP, 3 errored words, 1 good word, then 4 errored words -> stays UP after the first 3; ALIGNED after the 4th of the later run; err_cnt=7.
REQ-040 Preload err_cnt to 16'hFFFF (forced) plus one further errored word -> err_cnt holds 16'hFFFF; frm_cnt at 32'hFFFFFFFF plus one SOF -> frm_cnt=0.
REQ-041 clr_cnt asserted in the same cycle as an SOF in UP -> frm_cnt=0 next cycle, state stays UP.
REQ-042 Watchdog build, UP with no handshake word for 1024 cycles -> ALIGNED; non-watchdog build with the same stimulus -> stays UP.

Source files
------------

// File: rtl/hssl_link_mon.sv
// hssl_link_mon: GTH receive link-state monitor (DOWN/ALIGNED/HSHAKE/UP) with event counters.
// Define HSSL_LINK_MON_WDOG_EN to add a watchdog dropping UP after WDOG_CYCLES words without a handshake.
module hssl_link_mon #(
   parameter int unsigned HS_COUNT    = 8,
   parameter int unsigned ERR_LIMIT   = 4,
   parameter int unsigned WDOG_CYCLES = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] rx_data,
   input  logic [3:0]  rx_charisk,
   input  logic        rx_err,
   input  logic        rx_aligned,
   input  logic        clr_cnt,
   output logic        link_up,
   output logic [2:0]  state,
   output logic [15:0] hs_cnt,
   output logic [15:0] err_cnt,
   output logic [31:0] frm_cnt
);

   localparam int unsigned RUN_W  = $clog2(HS_COUNT + 1);
   localparam int unsigned ERUN_W = $clog2(ERR_LIMIT + 1);
   localparam int unsigned CNT_W  = 16;
   localparam int unsigned FRM_W  = 32;

   typedef enum logic [2:0] {
      S_DOWN    = 3'd0,
      S_ALIGNED = 3'd1,
      S_HSHAKE  = 3'd2,
      S_UP      = 3'd3
   } state_e;

   if (HS_COUNT == 0 || ERR_LIMIT == 0 || WDOG_CYCLES == 0) begin : g_param_check
      $error("hssl_link_mon: HS_COUNT, ERR_LIMIT and WDOG_CYCLES must be non-zero");
   end

   state_e              state_q, state_d;
   logic [RUN_W-1:0]    run_q, run_d;
   logic [ERUN_W-1:0]   err_run_q, err_run_d;
   logic                link_up_q;
   logic [CNT_W-1:0]    hs_cnt_q, err_cnt_q;
   logic [FRM_W-1:0]    frm_cnt_q;
   logic [1:0]          rst_sync_q;
   logic                run_en;
   logic                is_hs, is_sof, is_err;
   logic                unused_data;

   // Word classification: only byte 3 carries the K-character of interest.
   assign is_hs       = (rx_charisk == 4'b1000) && (rx_data[31:24] == 8'hBC);
   assign is_sof      = (rx_charisk == 4'b1000) && (rx_data[31:24] == 8'hFB);
   assign is_err      = rx_err || !((rx_charisk == 4'b0000) || (rx_charisk == 4'b1000));
   assign unused_data = ^rx_data[23:0];

   // Reset asserts asynchronously; release is held off two edges before the logic runs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rst_sync_q <= 2'b00;
      else        rst_sync_q <= {rst_sync_q[0], 1'b1};
   end
   assign run_en = rst_sync_q[1];

`ifdef HSSL_LINK_MON_WDOG_EN
   localparam int unsigned WD_W = $clog2(WDOG_CYCLES + 1);
   logic [WD_W-1:0] wdog_q, wdog_d;
`endif

   always_comb begin
      state_d   = state_q;
      run_d     = run_q;
      err_run_d = err_run_q;
`ifdef HSSL_LINK_MON_WDOG_EN
      wdog_d    = '0;
`endif
      if (!rx_aligned) begin
         state_d   = S_DOWN;
         run_d     = '0;
         err_run_d = '0;
      end else begin
         unique case (state_q)
            S_DOWN: state_d = S_ALIGNED;
            S_ALIGNED: begin
               if (is_hs) begin
                  if (HS_COUNT == 1) begin
                     state_d = S_UP;
                  end else begin
                     state_d = S_HSHAKE;
                     run_d   = RUN_W'(1);
                  end
               end
            end
            S_HSHAKE: begin
               if (!is_hs) begin
                  state_d = S_ALIGNED;
                  run_d   = '0;
               end else if (run_q == RUN_W'(HS_COUNT - 1)) begin
                  state_d = S_UP;
                  run_d   = '0;
               end else begin
                  run_d = run_q + RUN_W'(1);
               end
            end
            S_UP: begin
               if (!is_err) begin
                  err_run_d = '0;
               end else if (err_run_q == ERUN_W'(ERR_LIMIT - 1)) begin
                  state_d   = S_ALIGNED;
                  err_run_d = '0;
               end else begin
                  err_run_d = err_run_q + ERUN_W'(1);
               end
            end
            default: state_d = S_DOWN;
         endcase
`ifdef HSSL_LINK_MON_WDOG_EN
         // Watchdog counts consecutive non-handshake words while UP.
         if (state_q == S_UP && !is_hs) begin
            if (wdog_q == WD_W'(WDOG_CYCLES - 1)) begin
               state_d   = S_ALIGNED;
               err_run_d = '0;
            end else begin
               wdog_d = wdog_q + WD_W'(1);
            end
         end
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_DOWN;
         run_q     <= '0;
         err_run_q <= '0;
         link_up_q <= 1'b0;
`ifdef HSSL_LINK_MON_WDOG_EN
         wdog_q    <= '0;
`endif
      end else if (run_en) begin
         state_q   <= state_d;
         run_q     <= run_d;
         err_run_q <= err_run_d;
         link_up_q <= (state_d == S_UP);
`ifdef HSSL_LINK_MON_WDOG_EN
         wdog_q    <= wdog_d;
`endif
      end
   end

   // Event counters; clear wins over a same-cycle count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hs_cnt_q  <= '0;
         err_cnt_q <= '0;
         frm_cnt_q <= '0;
      end else if (run_en) begin
         if (clr_cnt) begin
            hs_cnt_q  <= '0;
            err_cnt_q <= '0;
            frm_cnt_q <= '0;
         end else begin
            if (state_q != S_DOWN && is_hs && hs_cnt_q != {CNT_W{1'b1}})
               hs_cnt_q <= hs_cnt_q + CNT_W'(1);
            if (state_q != S_DOWN && is_err && err_cnt_q != {CNT_W{1'b1}})
               err_cnt_q <= err_cnt_q + CNT_W'(1);
            if (state_q == S_UP && is_sof)
               frm_cnt_q <= frm_cnt_q + FRM_W'(1);
         end
      end
   end

   assign state   = state_q;
   assign link_up = link_up_q;
   assign hs_cnt  = hs_cnt_q;
   assign err_cnt = err_cnt_q;
   assign frm_cnt = frm_cnt_q;

endmodule

// File: tb/tb_hssl_link_mon.sv
// Directed self-checking bench for hssl_link_mon (default parameters).
module tb_hssl_link_mon;

   localparam logic [31:0] D_HS   = 32'hBC00_0000;
   localparam logic [31:0] D_SOF  = 32'hFB12_3456;
   localparam logic [31:0] D_IDLE = 32'h1234_5678;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] rx_data;
   logic [3:0]  rx_charisk;
   logic        rx_err;
   logic        rx_aligned;
   logic        clr_cnt;
   logic        link_up;
   logic [2:0]  state;
   logic [15:0] hs_cnt;
   logic [15:0] err_cnt;
   logic [31:0] frm_cnt;

   int n_checks = 0;
   int n_fails  = 0;

   hssl_link_mon dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx_data    (rx_data),
      .rx_charisk (rx_charisk),
      .rx_err     (rx_err),
      .rx_aligned (rx_aligned),
      .clr_cnt    (clr_cnt),
      .link_up    (link_up),
      .state      (state),
      .hs_cnt     (hs_cnt),
      .err_cnt    (err_cnt),
      .frm_cnt    (frm_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Present one word, let one rising edge sample it, return at the following falling edge.
   task automatic word(input logic [31:0] d, input logic [3:0] k, input logic e);
      rx_data    = d;
      rx_charisk = k;
      rx_err     = e;
      @(negedge clk);
   endtask

   task automatic hs_word();   word(D_HS,   4'b1000, 1'b0); endtask
   task automatic sof_word();  word(D_SOF,  4'b1000, 1'b0); endtask
   task automatic idle_word(); word(D_IDLE, 4'b0000, 1'b0); endtask
   task automatic err_word();  word(D_IDLE, 4'b0000, 1'b1); endtask

   initial begin
      rst_n      = 1'b0;
      rx_aligned = 1'b0;
      clr_cnt    = 1'b0;
      rx_data    = D_IDLE;
      rx_charisk = 4'b0000;
      rx_err     = 1'b0;
      repeat (3) @(negedge clk);

      check("rst_state",   32'(state),   32'd0);
      check("rst_link_up", 32'(link_up), 32'd0);
      check("rst_hs_cnt",  32'(hs_cnt),  32'd0);
      check("rst_frm_cnt", frm_cnt,      32'd0);

      // Release with alignment present: two synchroniser edges before the FSM moves.
      rst_n      = 1'b1;
      rx_aligned = 1'b1;
      idle_word();
      check("sync_edge1_state", 32'(state), 32'd0);
      idle_word();
      check("sync_edge2_state", 32'(state), 32'd0);
      idle_word();
      check("aligned_state", 32'(state), 32'd1);

      // Eight handshakes bring the link up.
      hs_word();
      check("hs1_state", 32'(state), 32'd2);
      repeat (6) hs_word();
      check("hs7_state",   32'(state),   32'd2);
      check("hs7_link_up", 32'(link_up), 32'd0);
      hs_word();
      check("hs8_state",   32'(state),   32'd3);
      check("hs8_link_up", 32'(link_up), 32'd1);
      check("hs8_hs_cnt",  32'(hs_cnt),  32'd8);

      // Loss of alignment forces DOWN.
      rx_aligned = 1'b0;
      idle_word();
      check("unaligned_state",   32'(state),   32'd0);
      check("unaligned_link_up", 32'(link_up), 32'd0);
      rx_aligned = 1'b1;
      idle_word();
      check("realign_state", 32'(state), 32'd1);

      // Broken handshake run returns to ALIGNED; only a full later run reaches UP.
      repeat (5) hs_word();
      check("hs5_state", 32'(state), 32'd2);
      idle_word();
      check("hs_break_state", 32'(state), 32'd1);
      repeat (7) hs_word();
      check("rerun7_state", 32'(state), 32'd2);
      hs_word();
      check("rerun8_state", 32'(state), 32'd3);
      check("rerun_hs_cnt", 32'(hs_cnt), 32'd21);

      // Three errors, one good word, then four errors drop UP.
      err_word();
      word(D_IDLE, 4'b0001, 1'b0);
      err_word();
      check("err3_state", 32'(state), 32'd3);
      idle_word();
      check("good_state", 32'(state), 32'd3);
      err_word();
      err_word();
      word(D_IDLE, 4'b0100, 1'b0);
      check("err_run3_state", 32'(state), 32'd3);
      err_word();
      check("err_run4_state",   32'(state),   32'd1);
      check("err_run4_link_up", 32'(link_up), 32'd0);
      check("err_cnt_7",        32'(err_cnt), 32'd7);

      // err_cnt saturation from a preloaded value.
      dut.err_cnt_q = 16'hFFFE;
      err_word();
      check("err_sat_ffff", 32'(err_cnt), 32'h0000_FFFF);
      err_word();
      check("err_sat_hold", 32'(err_cnt), 32'h0000_FFFF);

      // SOF outside UP is not counted.
      sof_word();
      check("sof_aligned_frm", frm_cnt,      32'd0);
      check("sof_aligned_st",  32'(state),   32'd1);
      repeat (8) hs_word();
      check("up_again_state", 32'(state),  32'd3);
      check("up_again_hs",    32'(hs_cnt), 32'd29);
      sof_word();
      check("sof_up_frm", frm_cnt, 32'd1);

      // frm_cnt wraps.
      dut.frm_cnt_q = 32'hFFFF_FFFF;
      sof_word();
      check("frm_wrap", frm_cnt, 32'd0);
      sof_word();
      check("frm_after_wrap", frm_cnt, 32'd1);

      // Clear beats a same-cycle SOF and leaves the FSM alone.
      clr_cnt = 1'b1;
      sof_word();
      clr_cnt = 1'b0;
      check("clr_frm",   frm_cnt,      32'd0);
      check("clr_hs",    32'(hs_cnt),  32'd0);
      check("clr_err",   32'(err_cnt), 32'd0);
      check("clr_state", 32'(state),   32'd3);
      sof_word();
      check("post_clr_frm", frm_cnt, 32'd1);

      // Long stretch without handshakes while UP.
      hs_word();
      repeat (1023) idle_word();
      check("wdog_1023_state", 32'(state), 32'd3);
      idle_word();
`ifdef HSSL_LINK_MON_WDOG_EN
      check("wdog_1024_state", 32'(state), 32'd1);
`else
      check("wdog_1024_state", 32'(state), 32'd3);
      repeat (100) idle_word();
      check("nowdog_1124_state", 32'(state), 32'd3);
`endif

      // Reset mid-handshake discards the partial run and the counters.
      rx_aligned = 1'b0;
      idle_word();
      rx_aligned = 1'b1;
      idle_word();
      repeat (3) hs_word();
      check("pre_rst_state", 32'(state), 32'd2);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_state",  32'(state),   32'd0);
      check("async_rst_hs_cnt", 32'(hs_cnt),  32'd0);
      check("async_rst_frm",    frm_cnt,      32'd0);
      check("async_rst_link",   32'(link_up), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) idle_word();
      check("post_rst_aligned", 32'(state), 32'd1);
      repeat (7) hs_word();
      check("post_rst_hs7", 32'(state), 32'd2);
      hs_word();
      check("post_rst_hs8",     32'(state),  32'd3);
      check("post_rst_hs_cnt",  32'(hs_cnt), 32'd8);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

   // Absolute time bound so the run always terminates.
   initial begin
      #200000;
      $display("FAIL timeout: observed no completion expected completion before 200000");
      $fatal(1, "timeout");
   end

endmodule
